// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/valid bus between the fetch unit (master) and imem (slave).
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Program counter owner: fetches one instruction at a time and holds it for the decoder until retire.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instr_fetch_unit_if.master         imem,
    output logic [31:0]                Instr,
    output logic                       InstrValid,
    output logic [31:0]                PCOut,
    output logic [31:0]                PCPlus4,
    input  logic                       Retire,
    input  logic                       Jump,
    input  logic                       Branch,
    input  logic                       Zero,
    input  logic [31:0]                SignImm,
    output logic                       FetchFault,
    output logic [31:0]                RetireCount
);

    localparam logic [1:0] FETCH_ARM = 2'd0;
    localparam logic [1:0] FETCH     = 2'd1;
    localparam logic [1:0] ISSUE     = 2'd2;
    localparam logic [1:0] HALT      = 2'd3;

    // Last wait-count value before the timeout fires on the next missing rvalid.
    localparam logic [7:0] WAIT_LAST = 8'(IMEM_TIMEOUT - 1);

    logic [1:0]  state;
    logic [31:0] pc;
    logic [7:0]  wait_cnt;
    logic [31:0] next_pc;
    logic        retire_ok;

    assign retire_ok  = (state == ISSUE) && Retire;

    // Request is gated by rst_n so it drops immediately while reset is held.
    assign imem.imem_req  = (state == FETCH) && rst_n;
    assign imem.imem_addr = pc;
    assign InstrValid     = (state == ISSUE);

    always_comb begin
        PCPlus4 = PCOut + 32'd4;
        if (Jump)
            next_pc = {PCPlus4[31:28], Instr[25:0], 2'b00};
        else if (Branch && Zero)
            next_pc = PCPlus4 + (SignImm << 2);
        else
            next_pc = PCPlus4;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FETCH_ARM;
            pc         <= RESET_PC;
            Instr      <= '0;
            PCOut      <= RESET_PC;
            wait_cnt   <= '0;
            FetchFault <= 1'b0;
        end else begin
            case (state)
                FETCH_ARM: state <= FETCH;
                FETCH: begin
                    if (imem.imem_rvalid) begin
                        Instr    <= imem.imem_rdata;
                        PCOut    <= pc;
                        wait_cnt <= '0;
                        state    <= ISSUE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        FetchFault <= 1'b1;
                        state      <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ISSUE: begin
                    if (Retire) begin
                        pc    <= next_pc;
                        state <= FETCH;
                    end
                end
                HALT:    state <= HALT;
                default: state <= FETCH_ARM;
            endcase
        end
    end

`ifdef INSTR_COUNT_EN
    logic [31:0] retire_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            retire_cnt <= '0;
        else if (retire_ok)
            retire_cnt <= retire_cnt + 32'd1;
    end

    assign RetireCount = retire_cnt;
`else
    logic unused_retire_ok;
    assign unused_retire_ok = retire_ok;
    assign RetireCount      = '0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the main decoder. Owns the program counter and fetches one instruction at a time from instruction memory over a request/valid handshake.
- Presents the instruction (and so the opcode, Instr[31:26]) to the decoder and holds it until the core signals retire.
- On retire, computes the next PC from the decoder's Jump/Branch outputs and the ALU Zero flag.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded while reset is asserted.
- IMEM_TIMEOUT, 255, max cycles spent in FETCH without imem_rvalid before a fault (range 1..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request, held high until imem_rvalid.
- imem_addr  out  32  fetch address (= PC).
- imem_rvalid  in  1  read data valid, single-cycle pulse.
- imem_rdata  in  32  instruction word.
- Instr  out  32  registered instruction to the decoder.
- InstrValid  out  1  Instr holds a fetched, unretired instruction.
- PCOut  out  32  address of Instr.
- PCPlus4  out  32  PCOut + 4.
- Retire  in  1  core has completed Instr; sampled only when InstrValid=1.
- Jump  in  1  from main decoder.
- Branch  in  1  from main decoder.
- Zero  in  1  ALU zero flag.
- SignImm  in  32  sign-extended immediate of Instr.
- FetchFault  out  1  sticky timeout flag.
- RetireCount  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values:
  - PC=RESET_PC, state=FETCH_ARM.
  - Instr=32'h0000_0000 (NOP), InstrValid=0, FetchFault=0, RetireCount=0, wait counter=0.
  - imem_req=0 while rst_n=0.
- States: FETCH_ARM, FETCH, ISSUE, HALT.
  - FETCH_ARM: lasts one cycle after reset release; imem_req=0; goes to FETCH.
  - FETCH:
    - imem_req=1, imem_addr=PC, combinational from state.
    - If imem_rvalid=1: Instr<=imem_rdata, PCOut<=PC, go to ISSUE, wait counter cleared.
    - Else wait counter increments. When it reaches IMEM_TIMEOUT, FetchFault<=1 and go to HALT.
    - Zero-wait memory is legal: rvalid may arrive in the first FETCH cycle.
  - ISSUE:
    - InstrValid=1, imem_req=0.
    - If Retire=1: update PC, go to FETCH.
    - Retire may be high in the first ISSUE cycle. Peak throughput is 1 instruction per 2 cycles.
  - HALT:
    - imem_req=0, InstrValid=0.
    - Left only by reset. FetchFault stays 1 until reset.
- Next-PC on retire:
  - Jump=1 (priority over branch): PC<={PCPlus4[31:28], Instr[25:0], 2'b00}.
  - Else Branch&Zero: PC<=PCPlus4 + (SignImm<<2), 32-bit wrap, carry dropped.
  - Else: PC<=PCPlus4.
  - PCPlus4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- Ignored inputs:
  - imem_rvalid outside FETCH is ignored; Instr is unchanged.
  - Retire, Jump, Branch and Zero outside ISSUE are ignored.
- Instr and PCOut stay stable through ISSUE and remain valid in the following FETCH (InstrValid=0).
- Reset mid-operation: rst_n=0 in any state returns to reset values at the next edge. An outstanding request is abandoned, and a late rvalid is ignored because the unit is in FETCH_ARM.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- Defined:
  - RetireCount increments by 1 on every accepted retire (ISSUE & Retire).
  - Wraps 32'hFFFF_FFFF -> 0. Cleared by reset.
- Undefined: RetireCount tied to 32'h0 and no counter register is synthesized.

Test Plan:
- Reset with RESET_PC=32'h0000_0040, release; zero-wait memory returns 32'h2008_0005 -> imem_req high on the second cycle after release with imem_addr=0x40; next cycle InstrValid=1, Instr=0x2008_0005, PCOut=0x40, PCPlus4=0x44.
- Sequential: Retire with Jump=0, Branch=0 -> next fetch address 0x44. Memory with 3-cycle latency -> imem_req held 3 cycles, InstrValid stays 0 until rvalid.
- Branch: PCOut=0x100, Branch=1, Zero=1, SignImm=32'hFFFF_FFFE, Retire -> next imem_addr=0xFC. Same case with Zero=0 -> 0x104.
- Jump priority: PCOut=0x1000_0010, Instr=0x0800_0004, Jump=1 and Branch=1, Zero=1, Retire -> next imem_addr=0x1000_0010.
- Timeout: IMEM_TIMEOUT=4, no rvalid -> FetchFault=1 after 4 FETCH cycles, imem_req=0, HALT persists; late rvalid and Retire are ignored; rst_n=0 clears FetchFault.
- With INSTR_COUNT_EN: retire 5 instructions -> RetireCount=5; assert rst_n=0 mid-FETCH -> RetireCount=0 and InstrValid=0 next edge.
